alu_arbiter: RTL and testbench

Shares the single 16-bit ALU between two requesters: requester 0 is the CPU execute stage and requester 1 is an auxiliary unit such as the address/DMA engine. It arbitrates round-robin, latches the winner's operands, drives the ALU for one execute cycle and captures the result and 5-bit flags. It returns them on a per-requester valid/ready response. It sits between the requesters and the ALU's reg1/reg2/instructionOp/inst/flagWrite inputs.

---
 rtl/alu_ctrl_pkg.sv | 33 +++
 rtl/alu_arbiter_if.sv | 38 +++
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/alu_arbiter.sv | 139 +++++++++++++
 tb/tb_alu_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ALU arbiter slice: controller state encoding,
// ALU opcode constants, flag bit positions and a small one-hot helper.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] ADD  = 8'h05;
  localparam logic [7:0] ADDI = 8'h50;
  localparam logic [7:0] SUB  = 8'h09;
  localparam logic [7:0] SUBI = 8'h90;
  localparam logic [7:0] CMP  = 8'h0B;
  localparam logic [7:0] CMPI = 8'hB0;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  // Expands a 2-way requester index into its one-hot strobe.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Request/response bundle between the two ALU requesters and the arbiter.
// Requester n owns bit n of every per-requester vector and slice n of every
// packed per-requester field.
//   req_valid/req_ready     : request handshake (ready is one-hot or zero)
//   req_a/req_b             : operands, requester n at [n*WIDTH +: WIDTH]
//   req_op/req_fn           : 8-bit opcode and 4-bit ALU function per requester
//   req_flag_we             : per-requester flag-write enable
//   resp_valid/resp_ready   : response handshake per requester
//   resp_result/resp_flags  : captured ALU result and flags
// Modports: master (requester side), slave (arbiter side).
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int WIDTH = 16
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [15:0]        req_op;
  logic [7:0]         req_fn;
  logic [1:0]         req_flag_we;
  logic [1:0]         resp_valid;
  logic [1:0]         resp_ready;
  logic [WIDTH-1:0]   resp_result;
  logic [4:0]         resp_flags;

  modport master (
    output req_valid, req_a, req_b, req_op, req_fn, req_flag_we, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_fn, req_flag_we, resp_ready,
    output req_ready, resp_valid, resp_result, resp_flags
  );
endinterface

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// requester that did not win last time gets the grant.
//   clk, reset   : clock, asynchronous active-high reset
//   enable       : arbitration allowed this cycle (controller idle)
//   valid[1:0]   : request vector
//   grant_valid  : a grant is being issued this cycle
//   grant        : index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] valid,
  output logic       grant_valid,
  output logic       grant
);
  logic last_grant;

  // Grant decode; a tie goes to the requester that lost last time.
  always_comb begin
    grant_valid = enable && (valid != 2'b00);
    grant       = 1'b0;
    unique case (valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  // Resetting to 1 makes requester 0 win the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (grant_valid) begin
      last_grant <= grant;
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one 16-bit ALU between the CPU execute stage (requester 0) and an
// auxiliary unit (requester 1). Each operation runs IDLE -> EXEC -> RESP:
// the winner's operands are latched on accept, driven to the ALU for one
// cycle, and the result plus the ALU flag register are captured at the end
// of that cycle and held until the winner takes the response.
//   clk, reset        : clock, asynchronous active-high reset
//   bus (slave)       : requester request/response bundle
//   alu_reg1/alu_reg2 : ALU operands (zero outside EXEC)
//   alu_op/alu_inst   : ALU instructionOp / inst (zero outside EXEC)
//   alu_flag_write    : ALU flagWrite, only during EXEC
//   alu_result        : combinational ALU result
//   alu_flags         : ALU flag register (updates on negedge clk)
//   busy              : controller not idle
//   grant_id          : current or last granted requester
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  alu_arbiter_if.slave             bus,
  output logic [WIDTH-1:0]         alu_reg1,
  output logic [WIDTH-1:0]         alu_reg2,
  output logic [7:0]               alu_op,
  output logic [3:0]               alu_inst,
  output logic                     alu_flag_write,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic [4:0]               alu_flags,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id
);
  state_t           state;
  state_t           state_nx;
  logic             arb_en;
  logic             gnt_valid;
  logic             gnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [7:0]       op_q;
  logic [3:0]       fn_q;
  logic             we_q;
  logic [WIDTH-1:0] result_q;
  logic [4:0]       flags_q;

  // Arbitration only happens while idle; gating with reset keeps req_ready
  // low for the whole time reset is held.
  assign arb_en = (state == IDLE) && !reset;

  rr_arbiter2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .enable      (arb_en),
    .valid       (bus.req_valid),
    .grant_valid (gnt_valid),
    .grant       (gnt)
  );

  assign bus.resp_result = result_q;
  assign bus.resp_flags  = flags_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and outputs. The ALU side is only driven during EXEC so the
  // ALU never sees stale operands or a stray flag write.
  always_comb begin
    state_nx       = state;
    bus.req_ready  = 2'b00;
    bus.resp_valid = 2'b00;
    alu_reg1       = '0;
    alu_reg2       = '0;
    alu_op         = '0;
    alu_inst       = '0;
    alu_flag_write = 1'b0;
    busy           = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (gnt_valid) begin
          bus.req_ready = onehot2(gnt);
          state_nx      = EXEC;
        end
      end
      EXEC: begin
        alu_reg1       = a_q;
        alu_reg2       = b_q;
        alu_op         = op_q;
        alu_inst       = fn_q;
        alu_flag_write = we_q;
        state_nx       = RESP;
      end
      RESP: begin
        bus.resp_valid = onehot2(grant_id);
        if (bus.resp_ready[grant_id]) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch on accept, and result/flag capture at the end of EXEC.
  // The flags are sampled after the ALU's mid-cycle negedge update, so they
  // already include this operation's effect when flag_we was set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      fn_q     <= '0;
      we_q     <= 1'b0;
      grant_id <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      if (state == IDLE && gnt_valid) begin
        a_q      <= gnt ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
        b_q      <= gnt ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
        op_q     <= gnt ? bus.req_op[15:8] : bus.req_op[7:0];
        fn_q     <= gnt ? bus.req_fn[7:4] : bus.req_fn[3:0];
        we_q     <= gnt ? bus.req_flag_we[1] : bus.req_flag_we[0];
        grant_id <= gnt;
      end
      if (state == EXEC) begin
        result_q <= alu_result;
        flags_q  <= alu_flags;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Bench for alu_arbiter with a behavioural ALU (combinational result, flag
// register written on negedge). Expected responses are queued when a request
// is accepted and compared when the arbiter hands the response back.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_ctrl_pkg::*;

  localparam int W = 16;

  typedef struct packed {
    logic          id;
    logic [W-1:0]  result;
    logic [4:0]    flags;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  alu_reg1;
  logic [W-1:0]  alu_reg2;
  logic [7:0]    alu_op;
  logic [3:0]    alu_inst;
  logic          alu_flag_write;
  logic [W-1:0]  alu_result;
  logic [4:0]    alu_flags = 5'b0;
  logic          busy;
  logic          grant_id;

  exp_t          sb_q[$];
  logic [4:0]    sb_flags = 5'b0;
  int            grant_log[$];
  int            accept_cyc[$];
  int            cyc = 0;
  int            fw_count = 0;
  int            total = 0;
  int            bad = 0;
  logic [W-1:0]  last_result = '0;
  logic [4:0]    last_flags = '0;
  logic [1:0]    last_valid = '0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W)) bus ();

  alu_arbiter #(.WIDTH(W), .NREQ(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .alu_reg1       (alu_reg1),
    .alu_reg2       (alu_reg2),
    .alu_op         (alu_op),
    .alu_inst       (alu_inst),
    .alu_flag_write (alu_flag_write),
    .alu_result     (alu_result),
    .alu_flags      (alu_flags),
    .busy           (busy),
    .grant_id       (grant_id)
  );

  // Behavioural ALU: fn[2:0] selects the operation, fn[3] turns add into subtract.
  function automatic logic [W-1:0] alu_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [3:0] fn);
    case (fn[2:0])
      3'd0:    return fn[3] ? a - b : a + b;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      default: return b;
    endcase
  endfunction

  // Add/sub opcodes update C and F; compares update L, Z and N; others keep flags.
  function automatic logic [4:0] flag_calc(input logic [7:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [3:0] fn,
                                           input logic [4:0] prior);
    logic [4:0] f;
    logic [W:0] s;
    f = prior;
    if (op == CMP || op == CMPI) begin
      f          = 5'b0;
      f[FLAG_Z]  = (a == b);
      f[FLAG_L]  = (a < b);
      f[FLAG_N]  = ($signed(a) < $signed(b));
    end else if (op == ADD || op == ADDI || op == SUB || op == SUBI) begin
      s = fn[3] ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      f[FLAG_C] = s[W];
      f[FLAG_F] = fn[3] ? ((a[W-1] != b[W-1]) && (s[W-1] != a[W-1]))
                        : ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1]));
    end
    return f;
  endfunction

  always_comb alu_result = alu_calc(alu_reg1, alu_reg2, alu_inst);

  always @(negedge clk) begin
    if (alu_flag_write) alu_flags <= flag_calc(alu_op, alu_reg1, alu_reg2, alu_inst, alu_flags);
  end

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on response handshake.
  logic          m_g;
  logic [W-1:0]  m_a;
  logic [W-1:0]  m_b;
  logic [7:0]    m_op;
  logic [3:0]    m_fn;
  logic          m_we;
  exp_t          m_e;
  always @(negedge clk) begin
    if (alu_flag_write) fw_count++;
    if (!reset && bus.req_ready != 2'b00) begin
      checkOutput("req_ready_onehot", 32'($onehot(bus.req_ready)), 32'd1);
      m_g  = bus.req_ready[1];
      m_a  = m_g ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
      m_b  = m_g ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
      m_op = m_g ? bus.req_op[15:8] : bus.req_op[7:0];
      m_fn = m_g ? bus.req_fn[7:4] : bus.req_fn[3:0];
      m_we = m_g ? bus.req_flag_we[1] : bus.req_flag_we[0];
      if (m_we) sb_flags = flag_calc(m_op, m_a, m_b, m_fn, sb_flags);
      m_e.id     = m_g;
      m_e.result = alu_calc(m_a, m_b, m_fn);
      m_e.flags  = sb_flags;
      sb_q.push_back(m_e);
      grant_log.push_back(int'(m_g));
      accept_cyc.push_back(cyc);
    end
    if (!reset && (bus.resp_valid & bus.resp_ready) != 2'b00) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_resp", 32'(bus.resp_valid), 32'd0);
      end else begin
        m_e = sb_q.pop_front();
        checkOutput("resp_valid", 32'(bus.resp_valid), 32'(onehot2(m_e.id)));
        checkOutput("resp_result", 32'(bus.resp_result), 32'(m_e.result));
        checkOutput("resp_flags", 32'(bus.resp_flags), 32'(m_e.flags));
        last_result = bus.resp_result;
        last_flags  = bus.resp_flags;
        last_valid  = bus.resp_valid;
      end
    end
  end

  task automatic setReq(input logic r, input logic [7:0] op, input logic [3:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic we);
    if (r) begin
      bus.req_a[2*W-1:W] = a;
      bus.req_b[2*W-1:W] = b;
      bus.req_op[15:8]   = op;
      bus.req_fn[7:4]    = fn;
    end else begin
      bus.req_a[W-1:0] = a;
      bus.req_b[W-1:0] = b;
      bus.req_op[7:0]  = op;
      bus.req_fn[3:0]  = fn;
    end
    bus.req_flag_we[r] = we;
  endtask

  // Raises one request, waits for its accept, then withdraws it (returns in EXEC).
  task automatic applyStimulus(input logic r, input logic [7:0] op, input logic [3:0] fn,
                               input logic [W-1:0] a, input logic [W-1:0] b, input logic we);
    logic ok;
    setReq(r, op, fn, a, b, we);
    bus.req_valid[r] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready[r]) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("accept_seen", 32'(ok), 32'd1);
    @(posedge clk);
    #1 bus.req_valid[r] = 1'b0;
  endtask

  task automatic waitDrain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("drain", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1 reset = 1'b1;
    bus.req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [4:0]   save_flags;
  int           fw_before;
  logic [1:0]   snap_valid;
  logic [W-1:0] snap_result;

  initial begin
    bus.req_valid   = 2'b00;
    bus.req_a       = '0;
    bus.req_b       = '0;
    bus.req_op      = '0;
    bus.req_fn      = '0;
    bus.req_flag_we = 2'b00;
    bus.resp_ready  = 2'b11;
    #2;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("reset_flag_write", 32'(alu_flag_write), 32'd0);
    checkOutput("reset_result", 32'(bus.resp_result), 32'd0);
    resetDut();

    // Requester 0 ADD with carry out.
    setReq(1'b0, ADD, 4'b0000, 16'hFFFF, 16'h0001, 1'b1);
    bus.req_valid = 2'b01;
    @(negedge clk);
    checkOutput("t1_req_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1 bus.req_valid = 2'b00;
    @(negedge clk);
    checkOutput("t1_exec_busy", 32'(busy), 32'd1);
    checkOutput("t1_exec_fw", 32'(alu_flag_write), 32'd1);
    checkOutput("t1_exec_reg1", 32'(alu_reg1), 32'hFFFF);
    checkOutput("t1_exec_no_resp", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    checkOutput("t1_resp_valid", 32'(bus.resp_valid), 32'h1);
    checkOutput("t1_resp_result", 32'(bus.resp_result), 32'h0000);
    checkOutput("t1_resp_flags", 32'(bus.resp_flags), 32'h01);
    waitDrain();

    // Requester 1 SUB without flag write keeps prior flags.
    fw_before = fw_count;
    applyStimulus(1'b1, SUB, 4'b1000, 16'h0003, 16'h0005, 1'b0);
    waitDrain();
    checkOutput("t2_resp_id", 32'(last_valid), 32'h2);
    checkOutput("t2_result", 32'(last_result), 32'hFFFE);
    checkOutput("t2_flags", 32'(last_flags), 32'h01);
    checkOutput("t2_no_flag_write", 32'(fw_count - fw_before), 32'd0);

    // Requester 0 CMP of equal operands.
    applyStimulus(1'b0, CMP, 4'b1000, 16'h0005, 16'h0005, 1'b1);
    waitDrain();
    checkOutput("t3_result", 32'(last_result), 32'h0000);
    checkOutput("t3_flags", 32'(last_flags), 32'h08);

    // Both requesting continuously: round-robin from requester 0.
    resetDut();
    grant_log.delete();
    accept_cyc.delete();
    setReq(1'b0, ADD, 4'b0000, 16'h1234, 16'h0101, 1'b1);
    setReq(1'b1, SUB, 4'b1000, 16'h8000, 16'h0001, 1'b1);
    bus.resp_ready = 2'b11;
    bus.req_valid  = 2'b11;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (grant_log.size() >= 4) break;
    end
    @(posedge clk);
    #1 bus.req_valid = 2'b00;
    checkOutput("t4_grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      checkOutput($sformatf("t4_grant%0d", i), 32'(grant_log[i]), 32'(i % 2));
      if (i > 0) checkOutput($sformatf("t4_spacing%0d", i), 32'(accept_cyc[i] - accept_cyc[i-1]), 32'd3);
    end
    waitDrain();

    // Stalled response: the non-granted ready bit must be ignored.
    bus.resp_ready = 2'b01;
    applyStimulus(1'b1, ADDI, 4'b0000, 16'h7FFF, 16'h0001, 1'b1);
    setReq(1'b0, 8'h33, 4'b0011, 16'h00F0, 16'h0FF0, 1'b0);
    bus.req_valid[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    snap_valid  = bus.resp_valid;
    snap_result = bus.resp_result;
    checkOutput("t5_resp_valid", 32'(snap_valid), 32'h2);
    checkOutput("t5_resp_result", 32'(snap_result), 32'h8000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t5_hold_valid", 32'(bus.resp_valid), 32'(snap_valid));
      checkOutput("t5_hold_result", 32'(bus.resp_result), 32'(snap_result));
      checkOutput("t5_hold_busy", 32'(busy), 32'd1);
      checkOutput("t5_no_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk);
    #1 bus.resp_ready = 2'b10;
    @(negedge clk);
    checkOutput("t5_still_resp", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("t5_idle", 32'(busy), 32'd0);
    checkOutput("t5_next_grant", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1 bus.req_valid = 2'b00;
    bus.resp_ready = 2'b11;
    waitDrain();

    // Reset in the middle of EXEC discards the operation.
    save_flags = sb_flags;
    setReq(1'b0, ADD, 4'b0000, 16'h0001, 16'h0002, 1'b1);
    bus.req_valid = 2'b01;
    @(negedge clk);
    @(posedge clk);
    #1 bus.req_valid = 2'b00;
    checkOutput("t6_exec_fw", 32'(alu_flag_write), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_fw", 32'(alu_flag_write), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("t6_rst_reg1", 32'(alu_reg1), 32'd0);
    sb_q.delete();
    sb_flags = save_flags;
    @(posedge clk);
    #1 bus.req_valid = 2'b11;
    #1;
    checkOutput("t6_rst_no_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("t6_first_grant", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1 bus.req_valid = 2'b00;
    waitDrain();

    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
